// File: rtl/fwd_fft_pkg.sv
// fwd_fft_pkg: shared widths and the round/saturate helper for the forward-FFT
// multiplier output path.
package fwd_fft_pkg;
    localparam int DEF_MUL_LAT = 3;
    localparam int PROD_W      = 32;
    localparam int DEF_OUT_W   = 16;

    // Round half up, shift right, clamp to out_w bits; bit PROD_W is the saturation flag.
    function automatic logic [PROD_W:0] round_sat(input logic [PROD_W-1:0] prod,
                                                  input int shift, input int out_w);
        logic [PROD_W:0] r;
        logic [PROD_W:0] max;
        r   = ({1'b0, prod} + ((PROD_W+1)'(1) << (shift - 1))) >> shift;
        max = ((PROD_W+1)'(1) << out_w) - (PROD_W+1)'(1);
        return (r > max) ? {1'b1, max[PROD_W-1:0]} : r;
    endfunction
endpackage

// File: rtl/fwd_fft_sync_fifo.sv
// fwd_fft_sync_fifo: small synchronous FIFO with a power-of-two depth; head
// entry is always visible on rdata.
module fwd_fft_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = r_count == (AW+1)'(DEPTH);
    assign empty = r_count == '0;
    assign count = r_count;
    assign rdata = r_mem[r_rptr];
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wdata;
    end
endmodule

// File: rtl/fwd_fft_mul_scale_out.sv
// fwd_fft_mul_scale_out: tracks validity through the pipelined multiplier, owns
// its clock-enable, scales each product and streams it out with frame-last.
module fwd_fft_mul_scale_out
    import fwd_fft_pkg::*;
#(
    parameter int MUL_LAT   = DEF_MUL_LAT,
    parameter int SHIFT     = 15,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mul_ce,
    input  logic [PROD_W-1:0] mul_dout,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    input  logic              sat_clr,
    output logic              sat_sticky
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int AW = $clog2(DEPTH);

    logic [MUL_LAT-1:0] r_vld;
    logic [CW-1:0]      r_frame_cnt;
    logic               r_sat_sticky;
    logic [PROD_W:0]    w_rs;
    logic [OUT_W:0]     w_head;
    logic [AW:0]        w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_last;

    assign w_rs       = round_sat(mul_dout, SHIFT, OUT_W);
    assign w_last     = r_frame_cnt == CW'(FRAME_LEN - 1);
    // Freeze the multiplier only when its oldest stage would overflow the FIFO.
    assign mul_ce     = !(w_full && r_vld[MUL_LAT-1]);
    assign in_ready   = mul_ce;
    assign w_push     = mul_ce && r_vld[MUL_LAT-1];
    assign out_valid  = w_count != '0;
    assign w_pop      = out_valid && out_ready;
    assign out_data   = w_empty ? '0 : w_head[OUT_W-1:0];
    assign out_last   = !w_empty && w_head[OUT_W];
    assign sat_sticky = r_sat_sticky;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld        <= '0;
            r_frame_cnt  <= '0;
            r_sat_sticky <= 1'b0;
        end else begin
            if (mul_ce) r_vld <= (r_vld << 1) | MUL_LAT'(in_valid);
            if (w_push) r_frame_cnt <= w_last ? '0 : r_frame_cnt + CW'(1);
            r_sat_sticky <= (w_push && w_rs[PROD_W]) || (r_sat_sticky && !sat_clr);
        end
    end

    fwd_fft_sync_fifo #(
        .WIDTH(OUT_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (w_push),
        .wdata  ({w_last, OUT_W'(w_rs)}),
        .pop    (w_pop),
        .rdata  (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );
endmodule

// File: tb/tb_fwd_fft_mul_scale_out.sv
// tb_fwd_fft_mul_scale_out: directed vectors plus hand-written stall, frame and
// reset sequences around a behavioural 3-stage multiplier with clock-enable.
module tb_fwd_fft_mul_scale_out;
    localparam int ML    = 3;
    localparam int DEPTH = 4;
    localparam int FL    = 8;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        last;
        logic        sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic        in_ready;
    logic        mul_ce;
    logic        out_valid;
    logic        out_last;
    logic        sat_sticky;
    logic [31:0] mul_dout;
    logic [15:0] out_data;
    logic [31:0] pipe [ML];
    vec_t        vecs [8];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= 32'(din0) * 32'(din1);
            for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_dout = pipe[ML-1];

    fwd_fft_mul_scale_out #(
        .MUL_LAT(ML), .SHIFT(15), .OUT_W(16), .DEPTH(DEPTH), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mul_ce(mul_ce), .mul_dout(mul_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .sat_clr(sat_clr), .sat_sticky(sat_sticky)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic single(input vec_t v);
        int lat;
        in_valid = 1'b1; din0 = v.a; din1 = v.b; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("vec_latency", lat, 4);
        chk("vec_data", out_data, v.d);
        chk("vec_last", out_last, v.last);
        chk("vec_sat", sat_sticky, v.sat);
        step();
    endtask

    // Feeds n samples whose scaled value is base+i; holds out_ready low for the first stall cycles.
    task automatic stream(input int n, input int base, input int fidx0, input int stall);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int extra = 0;
        logic acc;
        while (got < n && cyc < 300) begin
            if (stall > 0 && cyc == stall) begin
                chk("bp_accepted", sent, DEPTH + ML);
                chk("bp_mul_ce", mul_ce, 0);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_valid", out_valid, 1);
                chk("bp_head", out_data, base);
            end
            out_ready = cyc >= stall;
            in_valid = sent < n;
            din0 = 16'h8000;
            din1 = 16'(base + sent);
            acc = in_valid && mul_ce;
            if (out_valid && out_ready) begin
                chk("stream_data", out_data, 32'(base + got));
                chk("stream_last", out_last, ((fidx0 + got) % FL) == FL - 1);
                got++;
            end
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", got, n);
        repeat (8) begin
            if (out_valid) extra++;
            step();
        end
        chk("stream_dup", extra, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[1] = '{16'h0080, 16'h0080, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{16'h0081, 16'h007F, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'h0100, 16'h00C0, 16'h0002, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h7FFF, 16'hFFFD, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h8001, 16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_mul_ce", mul_ce, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat", sat_sticky, 0);

        for (int i = 0; i < 8; i++) single(vecs[i]);

        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_clear", sat_sticky, 0);

        in_valid = 1'b1; din0 = 16'hFFFF; din1 = 16'hFFFF;
        step();
        in_valid = 1'b0;
        step();
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_set_wins", sat_sticky, 1);
        chk("sat_push_valid", out_valid, 1);
        chk("sat_push_data", out_data, 16'hFFFF);
        step();

        stream(10, 1, 1, 20);

        do_reset();
        stream(20, 16'h0100, 0, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; din0 = 16'h8000; din1 = 16'(16'h0040 + i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        out_ready = 1'b1;
        begin
            int stale = 0;
            repeat (8) begin
                if (out_valid) stale++;
                step();
            end
            chk("no_stale_output", stale, 0);
        end
        stream(8, 16'h0050, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
